// File: rtl/starfield_layers_pkg.sv
// Shared constants and LFSR step function for starfield layers and other Galois LFSR users.
package starfield_layers_pkg;

  localparam int unsigned MaxLfsrW = 32;
  localparam int unsigned IdxW     = $clog2(MaxLfsrW);

  localparam logic [15:0] DefTaps = 16'b1000000001011;
  localparam logic [15:0] DefSeed = 16'h0001;

  typedef enum logic {StRun, StAdv} layer_state_e;

  // Galois step on the low w bits; callers truncate the result back to their width.
  function automatic logic [MaxLfsrW-1:0] lfsr_step(input logic [MaxLfsrW-1:0] l,
                                                    input logic [MaxLfsrW-1:0] taps,
                                                    input int unsigned         w);
    return (l << 1) ^ (l[IdxW'(w - 1)] ? taps : '0);
  endfunction

endpackage

// File: rtl/starfield_layer.sv
// One star layer: LFSR, per-frame base, advance counter, RUN/ADV FSM, star and colour decode.
module starfield_layer
  import starfield_layers_pkg::*;
#(
  parameter int unsigned        LFSR_W    = 16,
  parameter logic [LFSR_W-1:0] TAPS      = LFSR_W'(DefTaps),
  parameter logic [LFSR_W-1:0] SEED      = LFSR_W'(DefSeed),
  parameter int unsigned        DENSITY   = 7,
  parameter int unsigned        AREA_LOG2 = 9
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [9:0] i_hpos,
  input  logic [9:0] i_vpos,
  input  logic       i_frame_start,
  input  logic [3:0] i_speed,
  output logic       o_star_on,
  output logic [2:0] o_colour
);

  layer_state_e      r_state, w_state_d;
  logic [LFSR_W-1:0] r_lfsr, w_lfsr_d;
  logic [LFSR_W-1:0] r_base, w_base_d;
  logic [3:0]        r_cnt, w_cnt_d;
  logic [LFSR_W-1:0] w_step;
  logic              w_in_area;
  logic [2:0]        w_col;

  assign w_in_area = ((i_hpos >> AREA_LOG2) == 10'd0) && ((i_vpos >> AREA_LOG2) == 10'd0);
  assign w_step    = LFSR_W'(lfsr_step(MaxLfsrW'(r_lfsr), MaxLfsrW'(TAPS), LFSR_W));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= StRun;
    end else begin
      r_state <= w_state_d;
    end
  end

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StRun:   if (i_frame_start) w_state_d = StAdv;
      StAdv:   if (!i_frame_start && (r_cnt == 4'd0)) w_state_d = StRun;
      default: w_state_d = StRun;
    endcase
  end

  // A frame_start pulse always restarts the advance from the stored base.
  always_comb begin
    w_lfsr_d = r_lfsr;
    w_base_d = r_base;
    w_cnt_d  = r_cnt;
    unique case (r_state)
      StRun: begin
        if (i_frame_start) begin
          w_lfsr_d = r_base;
          w_cnt_d  = i_speed;
        end else if (w_in_area) begin
          w_lfsr_d = w_step;
        end
      end
      StAdv: begin
        if (i_frame_start) begin
          w_lfsr_d = r_base;
          w_cnt_d  = i_speed;
        end else if (r_cnt != 4'd0) begin
          w_lfsr_d = w_step;
          w_cnt_d  = r_cnt - 4'd1;
        end else begin
          w_base_d = r_lfsr;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_lfsr <= SEED;
      r_base <= SEED;
      r_cnt  <= 4'd0;
    end else begin
      r_lfsr <= w_lfsr_d;
      r_base <= w_base_d;
      r_cnt  <= w_cnt_d;
    end
  end

  assign w_col     = r_lfsr[2:0];
  assign o_star_on = (r_state == StRun) && w_in_area && (&r_lfsr[LFSR_W-1 -: DENSITY]);
  assign o_colour  = (w_col == 3'd0) ? 3'b111 : w_col;

endmodule

// File: rtl/starfield_layers.sv
// Multi-layer scrolling starfield: per-layer generators, lowest-index priority, registered rgb.
module starfield_layers
  import starfield_layers_pkg::*;
#(
  parameter int unsigned        LAYERS    = 2,
  parameter int unsigned        LFSR_W    = 16,
  parameter logic [LFSR_W-1:0] TAPS      = LFSR_W'(DefTaps),
  parameter logic [LFSR_W-1:0] SEED      = LFSR_W'(DefSeed),
  parameter int unsigned        DENSITY   = 7,
  parameter int unsigned        AREA_LOG2 = 9
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [9:0]            i_hpos,
  input  logic [9:0]            i_vpos,
  input  logic                  i_display_on,
  input  logic                  i_frame_start,
  input  logic [4*LAYERS-1:0]   i_speed,
  output logic [2:0]            o_rgb
);

  logic [LAYERS-1:0] w_star;
  logic [2:0]        w_colour [LAYERS];
  logic [2:0]        w_rgb_d;
  logic [2:0]        r_rgb;

  for (genvar k = 0; k < LAYERS; k++) begin : g_layer
    starfield_layer #(
      .LFSR_W    (LFSR_W),
      .TAPS      (TAPS),
      .SEED      (SEED + LFSR_W'(k)),
      .DENSITY   (DENSITY),
      .AREA_LOG2 (AREA_LOG2)
    ) u_layer (
      .i_clk         (i_clk),
      .i_rst_n       (i_rst_n),
      .i_hpos        (i_hpos),
      .i_vpos        (i_vpos),
      .i_frame_start (i_frame_start),
      .i_speed       (i_speed[4*k +: 4]),
      .o_star_on     (w_star[k]),
      .o_colour      (w_colour[k])
    );
  end

  // Scan from the highest index down so the lowest-index star ends up winning.
  always_comb begin
    w_rgb_d = 3'b000;
    for (int k = LAYERS - 1; k >= 0; k--) begin
      if (w_star[k]) w_rgb_d = w_colour[k];
    end
    if (!i_display_on) w_rgb_d = 3'b000;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rgb <= 3'b000;
    end else begin
      r_rgb <= w_rgb_d;
    end
  end

  assign o_rgb = r_rgb;

endmodule

// File: doc/starfield_layers.md
STARFIELD_LAYERS -- requirements
Module: starfield_layers

Interface
REQ-001 SHALL take parameter LAYERS, default 2: number of independent star layers, range 1..4.
REQ-002 SHALL take parameter LFSR_W, default 16: per-layer LFSR width.
REQ-003 SHALL take parameter TAPS, default 16'b1000000001011: Galois feedback mask, shared by all layers.
REQ-004 SHALL take parameter SEED, default 16'h0001: layer k seed = SEED + k; SEED + k = 0 is illegal.
REQ-005 SHALL take parameter DENSITY, default 7: number of top LFSR bits that must all be 1 for a star.
REQ-006 SHALL take parameter AREA_LOG2, default 9: active star area is 2^AREA_LOG2 x 2^AREA_LOG2, anchored at hpos = 0, vpos = 0.
REQ-007 SHALL have ports: clk, input, 1, sole clock.
REQ-008 SHALL have ports: reset, input, 1, asynchronous, active-low.
REQ-009 SHALL have ports: hpos, input, 10, current pixel column.
REQ-010 SHALL have ports: vpos, input, 10, current pixel row.
REQ-011 SHALL have ports: display_on, input, 1, visible-pixel qualifier.
REQ-012 SHALL have ports: frame_start, input, 1, one-cycle pulse issued in vertical blanking.
REQ-013 SHALL have ports: speed, input, 4*LAYERS, nibble k = scroll steps per frame for layer k.
REQ-014 SHALL have ports: rgb, output, 3, registered pixel colour.

Function
REQ-015 SHALL give each layer an LFSR stepping as next = {l[W-2:0],0} ^ (l[W-1] ? TAPS : 0).
REQ-016 SHALL give each layer a base register holding that layer's LFSR state at the start of the frame.
REQ-017 SHALL run a two-state FSM per layer: RUN and ADV.
REQ-018 RUN SHALL step the LFSR once on every cycle where hpos < 2^AREA_LOG2 and vpos < 2^AREA_LOG2; the LFSR holds otherwise.
REQ-019 RUN plus frame_start SHALL load lfsr <= base and cnt <= speed[k], then go to ADV.
REQ-020 ADV with cnt != 0 SHALL step the LFSR and decrement cnt, ignoring the area condition.
REQ-021 ADV with cnt = 0 SHALL load base <= lfsr and return to RUN in the same cycle.
REQ-022 Net effect: the layer k pattern advances speed[k] LFSR steps per frame.
REQ-023 speed[k] = 0 SHALL hold the field static: every frame is identical.
REQ-024 frame_start asserted while in ADV SHALL restart ADV: lfsr <= base, cnt <= speed[k]; base is not updated.
REQ-025 speed SHALL be sampled only on frame_start; later changes take effect at the next frame.
REQ-026 Layer k star_on SHALL be the AND of lfsr[W-1 : W-DENSITY], evaluated only in RUN inside the area.
REQ-027 Layer k colour SHALL be lfsr[2:0]; a colour of 0 is forced to 3'b111.
REQ-028 Priority: the lowest-index layer with star_on SHALL win.
REQ-029 rgb SHALL be registered with 1-cycle latency: rgb(t+1) = display_on(t) && any star(t) ? winner colour : 0.
REQ-030 display_on = 0 SHALL force rgb to 0 without affecting LFSR stepping.

Reset
REQ-031 On reset low, asynchronously: lfsr_k = base_k = SEED + k, cnt = 0, state = RUN, rgb = 0.
REQ-032 Reset mid-ADV SHALL abandon the advance; base is not updated.
REQ-033 Release SHALL be synchronised by the existing reset scheme; the first active edge follows REQ-018.

Structure
REQ-034 Sub-module starfield_layer SHALL implement one layer: LFSR, base, cnt, FSM, star_on, colour.
REQ-035 The top level SHALL generate LAYERS instances and contain the priority mux plus the rgb register.
REQ-036 The LFSR step function and default TAPS/SEED SHALL live in a shared include of constants, reusable by other LFSR users.
REQ-037 The LFSR stepping of REQ-015 SHALL NOT instantiate the existing single-enable LFSR module, because load/advance control is required.

Verification
REQ-038 Reset: hold reset low 5 cycles -> rgb = 0; layer0 lfsr = 16'h0001; layer1 lfsr = 16'h0002; state = RUN.
REQ-039 Static field: LAYERS = 1, speed = 0, two full 640x480 frames -> rgb sequences identical pixel-for-pixel.
REQ-040 Scroll: speed[0] = 3 -> frame N+1 star at (row r, col c) equals frame N star at linear pixel index r*512 + c + 3, wrapping modulo the area.
REQ-041 Advance timing: frame_start pulse with speed = 5 -> exactly 5 LFSR steps in ADV, base updated on cycle 6, back in RUN.
REQ-042 Priority/blank: force both layers to star_on with colours 3'b010 and 3'b101 -> rgb = 3'b010 one cycle later; same pixel with display_on = 0 -> rgb = 0.
REQ-043 Re-trigger and reset: frame_start at ADV cycle 2 -> ADV restarts from base; reset low at ADV cycle 2 -> lfsr = SEED, base = SEED, state = RUN.
